mem_port_arbiter: RTL

- Shares one single-ported unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store) of the MIPS32 pipeline.
- Arbitrates requests and sequences the variable-latency memory handshake.
- Returns read data and produces per-stage stall signals that freeze the PC and the pipeline registers while an access is outstanding.
- Data port has priority, bounded by a starvation limit that guarantees fetch progress.

---
 rtl/mem_port_arbiter_if.sv | 38 +++
 rtl/mem_port_arbiter.sv | 103 ++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the memory arbiter and the
// unified single-ported memory. The arbiter connects through the slave
// modport. The environment side (pipeline stages plus memory) connects
// through the master modport.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // fetch port
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  // data port
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  // memory side
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_ack;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    output if_rdata, if_ready, d_rdata, d_ready, m_req, m_we, m_addr, m_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    input  if_rdata, if_ready, d_rdata, d_ready, m_req, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and
// load/store. The data port wins ties. After MAX_DSTREAK consecutive data
// grants taken while a fetch was waiting, the fetch is forced through.
// Address and data widths come from the interface parameters.
//
// state | meaning
// IDLE  | no access outstanding, requests sampled at the clock edge
// WAIT  | m_req held with latched address/data, waiting for m_ack
// RESP  | owner's ready pulses this cycle, grant clears at the next edge
module mem_port_arbiter #(
  parameter int MAX_DSTREAK = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus,
  output logic                 stall_if,
  output logic                 stall_mem,
  output logic [1:0]           grant
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int SW = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] DMAX = SW'(MAX_DSTREAK);

  state_t        state;
  logic [SW-1:0] dstreak;
  logic          pick_d;
  logic          pick_i;

  // Grant decision for the IDLE edge: data first unless the fetch has waited too long.
  always_comb begin
    pick_d = bus.d_req & (~bus.if_req | (dstreak < DMAX));
    pick_i = bus.if_req & ~pick_d;
  end

  // Stalls drop in the ready cycle so each stage advances exactly once per access.
  assign stall_if  = bus.if_req & ~bus.if_ready;
  assign stall_mem = bus.d_req & ~bus.d_ready;

  // Arbitration FSM with registered memory-side and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      dstreak      <= '0;
      grant        <= 2'b00;
      bus.m_req    <= 1'b0;
      bus.m_we     <= 1'b0;
      bus.m_addr   <= '0;
      bus.m_wdata  <= '0;
      bus.if_rdata <= '0;
      bus.d_rdata  <= '0;
      bus.if_ready <= 1'b0;
      bus.d_ready  <= 1'b0;
    end else begin
      bus.if_ready <= 1'b0;
      bus.d_ready  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_d) begin
            bus.m_addr  <= bus.d_addr;
            bus.m_we    <= bus.d_we;
            bus.m_wdata <= bus.d_wdata;
            bus.m_req   <= 1'b1;
            grant       <= 2'b10;
            // Only data grants that make a fetch wait count toward the streak.
            if (bus.if_req)
              dstreak <= (dstreak == DMAX) ? DMAX : dstreak + SW'(1);
            else
              dstreak <= '0;
            state <= WAIT;
          end else if (pick_i) begin
            bus.m_addr <= bus.if_addr;
            bus.m_we   <= 1'b0;
            bus.m_req  <= 1'b1;
            grant      <= 2'b01;
            dstreak    <= '0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (bus.m_ack) begin
            bus.m_req <= 1'b0;
            // Stores leave the load-data register untouched.
            if (!bus.m_we) begin
              if (grant == 2'b01) bus.if_rdata <= bus.m_rdata;
              else                bus.d_rdata  <= bus.m_rdata;
            end
            if (grant == 2'b01) bus.if_ready <= 1'b1;
            else                bus.d_ready  <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          grant <= 2'b00;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
